pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//   Game-flow sequencer for the pong datapath: idle/attract, serve countdown, rally, point pause and game over.
//   Sits between the debounced start button, the ball/paddle update logic and the frame generator.
//   Gates ball motion (ball_run), requests ball recentering (ball_reset), picks the serve direction and keeps score.
//   All timing is counted in frames via a one-cycle frame_tick derived from the frame clock.
// PARAMETERS
//   WIN_SCORE     7   points needed to win; must be <= 2**SCORE_W-1
//   SERVE_FRAMES  60  frame ticks the ball is held centred before a serve
//   POINT_FRAMES  90  frame ticks play is frozen after a point
//   SCORE_W       4   width of each score counter
// PORTS
//   clk         in   1        pixel clock (single clock domain)
//   rst_n       in   1        asynchronous reset, active low
//   frame_tick  in   1        one-clk pulse per frame, synchronous to clk
//   start       in   1        debounced start button, level
//   miss_l      in   1        one-clk pulse: ball left the field past the left paddle
//   miss_r      in   1        one-clk pulse: ball left the field past the right paddle
//   ball_run    out  1        1 = ball datapath may advance on frame ticks
//   ball_reset  out  1        one-clk pulse: recentre the ball and load serve_dir
//   serve_dir   out  2        serve direction, ball encoding: 00 up_l, 01 dw_l, 10 dw_r, 11 up_r
//   score_l     out  SCORE_W  left player score
//   score_r     out  SCORE_W  right player score
//   game_over   out  1        1 while in OVER
//   winner      out  1        0 = left, 1 = right; valid while game_over = 1
//   state       out  3        current FSM state, for debug/overlay
// BEHAVIOUR
//   Reset (async, rst_n = 0): state = IDLE, scores = 0, ball_run = 0, ball_reset = 0, serve_dir = 2'b11,
//     game_over = 0, winner = 0, frame counter = 0, start_q = 0. Takes effect immediately, including mid-rally.
//   States: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4. Codes 5-7 return to IDLE on the next clk.
//   start_rise = start & ~start_q (start_q is registered every clk). Only IDLE and OVER act on start_rise.
//   All outputs are registered. Outputs change on the edge that performs the transition, so a new state's
//     values are visible one clk after the triggering input.
//   IDLE: on start_rise -> SERVE. Clear scores, game_over = 0, serve_dir = 11, pulse ball_reset, cnt = SERVE_FRAMES.
//   SERVE: ball_run = 0. Each frame_tick decrements cnt. The tick that takes cnt 1->0 moves to PLAY with ball_run = 1.
//     Hold time is exactly SERVE_FRAMES ticks.
//   PLAY: ball_run = 1.
//     miss_l only: score_r + 1, serve_dir = 00 (serve toward the player who missed).
//     miss_r only: score_l + 1, serve_dir = 11.
//     miss_l and miss_r in the same clk: no score change, serve_dir unchanged.
//     Any miss: ball_run = 0 on the same edge.
//     If an updated score == WIN_SCORE -> OVER with game_over = 1 and winner set; otherwise -> POINT with cnt = POINT_FRAMES.
//   POINT: ball_run = 0. Count down POINT_FRAMES ticks. Final tick: pulse ball_reset, cnt = SERVE_FRAMES, -> SERVE.
//   OVER: ball_run = 0; scores, winner and game_over held. start_rise behaves exactly as in IDLE.
//   Ignored inputs: miss_* outside PLAY, start outside IDLE/OVER, frame_tick in IDLE/PLAY/OVER.
//   frame_tick coinciding with a miss in PLAY: the miss is processed and the tick has no effect.
//   Scores never exceed WIN_SCORE (no wrap).
//   cnt width = clog2(max(SERVE_FRAMES, POINT_FRAMES) + 1). Parameter value 0 is treated as 1.
// TESTING
//   1. Reset, start pulse -> ball_reset high for 1 clk; state = SERVE; ball_run rises after exactly 60 frame_ticks.
//   2. In PLAY, one miss_r -> score_l = 1, serve_dir = 11, ball_run = 0 next clk;
//      ball_reset after 90 ticks; PLAY again 60 ticks later.
//   3. Seven miss_l events -> score_r = 7, game_over = 1, winner = 1, ball_run = 0;
//      further miss_* and frame_ticks leave all outputs unchanged.
//   4. miss_l and miss_r in the same clk -> scores unchanged, state = POINT.
//   5. Assert rst_n = 0 mid-PLAY with score 3-2 -> all outputs at reset values without a clk edge;
//      start held high through reset release does not start a game until it falls and rises again.
//   6. start held high in OVER, then re-pressed -> scores = 0, game_over = 0, exactly one ball_reset pulse, state = SERVE.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game-flow sequencer for the pong datapath. It steps through idle/attract,
//   serve countdown, rally, point pause and game over. It gates ball motion,
//   requests ball recentering, chooses the serve direction and keeps score.
//   Every timed phase is counted in frames using the one-clk frame_tick pulse.
//
// Ports
//   clk         in   1        pixel clock (single clock domain)
//   rst_n       in   1        asynchronous reset, active low
//   frame_tick  in   1        one-clk pulse per frame, synchronous to clk
//   start       in   1        debounced start button, level
//   miss_l      in   1        one-clk pulse: ball passed the left paddle
//   miss_r      in   1        one-clk pulse: ball passed the right paddle
//   ball_run    out  1        1 = ball datapath may advance on frame ticks
//   ball_reset  out  1        one-clk pulse: recentre ball, load serve_dir
//   serve_dir   out  2        00 up_l, 01 dw_l, 10 dw_r, 11 up_r
//   score_l     out  SCORE_W  left player score
//   score_r     out  SCORE_W  right player score
//   game_over   out  1        1 while in OVER
//   winner      out  1        0 = left, 1 = right (valid while game_over)
//   state       out  3        current FSM state (IDLE 0 .. OVER 4)
//
// Handshake note: there is no valid/ready pair on this block. The outputs
// are plain registered levels. ball_reset is a single-cycle strobe, and the
// datapath acts on it in the cycle it is high.
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               ball_run,
    output logic               ball_reset,
    output logic [1:0]         serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    // A frame count of 0 would make a phase last no time, so it is treated as 1.
    localparam int SF   = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
    localparam int PF   = (POINT_FRAMES < 1) ? 1 : POINT_FRAMES;
    localparam int MAXF = (SF > PF) ? SF : PF;
    localparam int CW   = $clog2(MAXF + 1);

    localparam logic [CW-1:0]      SF_C  = CW'(SF);
    localparam logic [CW-1:0]      PF_C  = CW'(PF);
    localparam logic [CW-1:0]      ONE_C = CW'(1);
    localparam logic [SCORE_W-1:0] WIN_C = SCORE_W'(WIN_SCORE);

    localparam logic [1:0] DIR_UP_L = 2'b00;
    localparam logic [1:0] DIR_UP_R = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_start_q;
    logic               r_start_armed;
    logic               r_ball_run;
    logic               r_ball_reset;
    logic [1:0]         r_serve_dir;
    logic [SCORE_W-1:0] r_score_l;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_game_over;
    logic               r_winner;

    logic               w_start_rise;
    logic               w_cnt_last;
    logic [SCORE_W-1:0] w_score_l_nxt;
    logic [SCORE_W-1:0] w_score_r_nxt;

    // r_start_armed is cleared by reset. It is set again only after start has
    // been seen low. Without it, a button held down through reset release would
    // look like a fresh press, because r_start_q comes out of reset at 0.
    assign w_start_rise  = start & ~r_start_q & r_start_armed;
    assign w_cnt_last    = (r_cnt <= ONE_C);
    assign w_score_l_nxt = r_score_l + SCORE_W'(1);
    assign w_score_r_nxt = r_score_r + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_start_q     <= 1'b0;
            r_start_armed <= 1'b0;
            r_ball_run    <= 1'b0;
            r_ball_reset  <= 1'b0;
            r_serve_dir   <= DIR_UP_R;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_start_q    <= start;
            r_ball_reset <= 1'b0;
            if (!start) begin
                r_start_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_OVER: begin
                    r_ball_run <= 1'b0;
                    if (w_start_rise) begin
                        r_state      <= S_SERVE;
                        r_score_l    <= '0;
                        r_score_r    <= '0;
                        r_game_over  <= 1'b0;
                        r_serve_dir  <= DIR_UP_R;
                        r_ball_reset <= 1'b1;
                        r_cnt        <= SF_C;
                    end
                end

                S_SERVE: begin
                    r_ball_run <= 1'b0;
                    if (frame_tick) begin
                        if (w_cnt_last) begin
                            r_cnt      <= '0;
                            r_state    <= S_PLAY;
                            r_ball_run <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - ONE_C;
                        end
                    end
                end

                // A miss takes priority over a frame_tick in the same clk.
                // Misses on both sides at once cancel each other: no score
                // changes and the serve direction stays as it was.
                S_PLAY: begin
                    r_ball_run <= 1'b1;
                    if (miss_l || miss_r) begin
                        r_ball_run <= 1'b0;
                        r_state    <= S_POINT;
                        r_cnt      <= PF_C;
                        if (miss_l && !miss_r) begin
                            r_serve_dir <= DIR_UP_L;
                            if (r_score_r < WIN_C) begin
                                r_score_r <= w_score_r_nxt;
                            end
                            if (w_score_r_nxt >= WIN_C) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                                r_winner    <= 1'b1;
                            end
                        end else if (miss_r && !miss_l) begin
                            r_serve_dir <= DIR_UP_R;
                            if (r_score_l < WIN_C) begin
                                r_score_l <= w_score_l_nxt;
                            end
                            if (w_score_l_nxt >= WIN_C) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                                r_winner    <= 1'b0;
                            end
                        end
                    end
                end

                S_POINT: begin
                    r_ball_run <= 1'b0;
                    if (frame_tick) begin
                        if (w_cnt_last) begin
                            r_ball_reset <= 1'b1;
                            r_cnt        <= SF_C;
                            r_state      <= S_SERVE;
                        end else begin
                            r_cnt <= r_cnt - ONE_C;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_ball_run <= 1'b0;
                end
            endcase
        end
    end

    assign ball_run   = r_ball_run;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed bench for pong_game_ctrl. The stimulus hand-computes every output
//   change it expects and pushes that change onto exp_q. The monitor samples
//   the packed output vector 1 time unit after each rising edge. Whenever the
//   vector changes, the monitor pops the next expected value and compares.
//   Points where outputs must hold are also checked directly.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    localparam int SF = 60;
    localparam int PF = 90;
    localparam int W  = 17;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start      = 1'b0;
    logic       miss_l     = 1'b0;
    logic       miss_r     = 1'b0;
    logic       ball_run;
    logic       ball_reset;
    logic [1:0] serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    pong_game_ctrl #(
        .WIN_SCORE   (7),
        .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF),
        .SCORE_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .start     (start),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .ball_run  (ball_run),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [W-1:0] exp_q[$];
    string        nm_q[$];
    bit           mon_en = 1'b0;
    logic [W-1:0] prev_vec;
    logic [W-1:0] mon_ev;
    string        mon_nm;

    // Expected output fields, maintained by hand in the stimulus.
    logic [2:0] e_state;
    logic       e_run;
    logic       e_rst;
    logic [1:0] e_dir;
    logic [3:0] e_sl;
    logic [3:0] e_sr;
    logic       e_go;
    logic       e_win;

    wire [W-1:0] dut_vec = {state, ball_run, ball_reset, serve_dir,
                            score_l, score_r, game_over, winner};

    function automatic logic [W-1:0] exp_vec();
        return {e_state, e_run, e_rst, e_dir, e_sl, e_sr, e_go, e_win};
    endfunction

    function automatic string fmt(logic [W-1:0] v);
        return $sformatf("st=%0d run=%0b rst=%0b dir=%b sl=%0d sr=%0d go=%0b win=%0b",
                         v[16:14], v[13], v[12], v[11:10], v[9:6], v[5:2], v[1], v[0]);
    endfunction

    task automatic push(input string n);
        exp_q.push_back(exp_vec());
        nm_q.push_back(n);
    endtask

    task automatic check_now(input string n);
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL %s: got %s expected %s", n, fmt(dut_vec), fmt(exp_vec()));
        end
    endtask

    task automatic set_reset_exp();
        e_state = 3'd0; e_run = 1'b0; e_rst = 1'b0; e_dir = 2'b11;
        e_sl = 4'd0; e_sr = 4'd0; e_go = 1'b0; e_win = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (mon_en && (dut_vec !== prev_vec)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: got %s expected unchanged %s",
                         fmt(dut_vec), fmt(prev_vec));
            end else begin
                mon_ev = exp_q.pop_front();
                mon_nm = nm_q.pop_front();
                if (dut_vec !== mon_ev) begin
                    failures++;
                    $display("FAIL %s: got %s expected %s", mon_nm, fmt(dut_vec), fmt(mon_ev));
                end
            end
            prev_vec = dut_vec;
        end
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic step(input bit ft, input bit ml, input bit mr);
        frame_tick = ft;
        miss_l     = ml;
        miss_r     = mr;
        @(negedge clk);
        frame_tick = 1'b0;
        miss_l     = 1'b0;
        miss_r     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_game(input string n);
        start = 1'b1;
        e_state = 3'd1; e_sl = 4'd0; e_sr = 4'd0; e_go = 1'b0;
        e_dir = 2'b11; e_rst = 1'b1; e_run = 1'b0;
        push({n, "_start"});
        step(1'b0, 1'b0, 1'b0);
        e_rst = 1'b0;
        push({n, "_pulse_end"});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_now({n, "_single_pulse"});
    endtask

    // Ball is held for SF-1 ticks; the SF-th tick starts play.
    task automatic serve_phase();
        ticks(SF - 1);
        check_now("serve_hold");
        e_state = 3'd2; e_run = 1'b1;
        push("serve_to_play");
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic point_phase();
        ticks(PF - 1);
        check_now("point_hold");
        e_state = 3'd1; e_rst = 1'b1;
        push("point_reset_pulse");
        step(1'b1, 1'b0, 1'b0);
        e_rst = 1'b0;
        push("point_pulse_end");
        step(1'b0, 1'b0, 1'b0);
        serve_phase();
    endtask

    task automatic miss(input bit ft, input bit ml, input bit mr, input string n);
        e_run = 1'b0;
        if (ml && !mr) begin
            e_sr++;
            e_dir = 2'b00;
        end else if (mr && !ml) begin
            e_sl++;
            e_dir = 2'b11;
        end
        if (e_sl == 4'd7 || e_sr == 4'd7) begin
            e_state = 3'd4; e_go = 1'b1; e_win = (e_sr == 4'd7);
        end else begin
            e_state = 3'd3;
        end
        push(n);
        step(ft, ml, mr);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_reset_exp();
        #2 rst_n = 1'b0;
        #1 check_now("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_now("idle_ignores_inputs");
        prev_vec = dut_vec;
        mon_en   = 1'b1;

        // First serve: ball_run rises on exactly the 60th tick.
        start_game("game1");
        serve_phase();

        // A right-side miss scores for the left player; then pause and serve.
        miss(1'b0, 1'b0, 1'b1, "miss_r");
        point_phase();

        // Simultaneous misses: no score change, still a point pause.
        miss(1'b0, 1'b1, 1'b1, "double_miss");
        point_phase();

        // A miss and a frame_tick in the same clk: the tick is ignored.
        miss(1'b1, 1'b1, 1'b0, "miss_l_with_tick");
        point_phase();

        for (int i = 0; i < 5; i++) begin
            miss(1'b0, 1'b1, 1'b0, "miss_l");
            point_phase();
        end

        // start pressed during play is ignored and stays held into OVER.
        start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_now("start_ignored_in_play");
        miss(1'b0, 1'b1, 1'b0, "miss_l_win");
        check_now("game_over_right");

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b1);
        end
        check_now("over_hold");

        // Re-press start in OVER; winner is not touched by the restart.
        start = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_now("over_start_released");
        start_game("restart");
        serve_phase();

        // Build a 3-2 score, then reset asynchronously in the middle of play.
        for (int i = 0; i < 3; i++) begin
            miss(1'b0, 1'b0, 1'b1, "miss_r_build");
            point_phase();
        end
        for (int i = 0; i < 2; i++) begin
            miss(1'b0, 1'b1, 1'b0, "miss_l_build");
            point_phase();
        end
        check_now("pre_reset_3_2");

        set_reset_exp();
        push("async_reset");
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_now("reset_no_clk");
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        check_now("start_held_through_reset");
        start = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_now("start_released_after_reset");
        start_game("after_reset");
        serve_phase();

        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
